// File: rtl/adc_trigger_capture.sv
// Oscilloscope capture stage: records DEPTH samples around a level trigger, PRE_TRIG of them before it.
// Optional falling-slope trigger selection is compiled in with `define SCOPE_TRIG_SLOPE_EN.
module adc_trigger_capture #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 9,
  parameter int PRE_TRIG = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              arm,
  input  logic              force_trig,
`ifdef SCOPE_TRIG_SLOPE_EN
  input  logic              trig_slope,
`endif
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 2);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

  typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POST, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] start_ptr;
  logic [DATA_W-1:0] prev_sample;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_index;
  logic              wr_en;
  logic              crossing;
  logic              arm_ok;

  assign busy     = (state == PREFILL) || (state == WAIT_TRIG) || (state == POST);
  assign done     = (state == DONE);
  assign wr_en    = s_valid && busy;
  assign arm_ok   = arm && ((state == IDLE) || (state == DONE));
  assign rd_index = start_ptr + rd_addr;

`ifdef SCOPE_TRIG_SLOPE_EN
  logic slope_q;

  // Slope is latched at arm so a capture in flight keeps its edge polarity.
  always_ff @(posedge clk) begin
    if (reset)
      slope_q <= 1'b0;
    else if (arm_ok)
      slope_q <= trig_slope;
  end

  assign crossing = slope_q ? ((prev_sample > trig_level) && (s_data <= trig_level))
                            : ((prev_sample < trig_level) && (s_data >= trig_level));
`else
  assign crossing = (prev_sample < trig_level) && (s_data >= trig_level);
`endif

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= '0;
    else
      rd_data <= mem[rd_index];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      cnt         <= '0;
      start_ptr   <= '0;
      prev_sample <= '0;
      triggered   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr      <= wr_ptr + 1'b1;
        prev_sample <= s_data;
      end
      unique case (state)
        IDLE, DONE: begin
          if (arm) begin
            state     <= PREFILL;
            wr_ptr    <= '0;
            cnt       <= '0;
            triggered <= 1'b0;
          end
        end
        PREFILL: begin
          if (s_valid) begin
            if (cnt == PRE_LAST)
              state <= WAIT_TRIG;
            else
              cnt <= cnt + 1'b1;
          end
        end
        WAIT_TRIG: begin
          if (force_trig || (s_valid && crossing)) begin
            state     <= POST;
            start_ptr <= wr_ptr - PRE_OFS;
            triggered <= 1'b1;
            // A forced trigger without a sample still owes the trigger write, so count from -1.
            cnt       <= s_valid ? '0 : '1;
          end
        end
        POST: begin
          if (s_valid) begin
            if (cnt == POST_LAST)
              state <= DONE;
            else
              cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Directed testbench for adc_trigger_capture: sample k = 8k mod 4096, one s_valid every 4 clocks.
// Falling-slope scenario runs only when SCOPE_TRIG_SLOPE_EN is defined.
module tb_adc_trigger_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [11:0] s_data;
  logic [11:0] trig_level;
  logic        arm;
  logic        force_trig;
`ifdef SCOPE_TRIG_SLOPE_EN
  logic        trig_slope;
`endif
  logic [8:0]  rd_addr;
  logic [11:0] rd_data;
  logic        busy;
  logic        triggered;
  logic        done;

  int compared   = 0;
  int mismatched = 0;
  int k          = 0;

  always #5 clk = ~clk;

  adc_trigger_capture #(.DATA_W(12), .ADDR_W(9), .PRE_TRIG(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .trig_level (trig_level),
    .arm        (arm),
    .force_trig (force_trig),
`ifdef SCOPE_TRIG_SLOPE_EN
    .trig_slope (trig_slope),
`endif
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One sample strobe followed by three idle clocks.
  task automatic apply_stimulus();
    s_valid = 1'b1;
    s_data  = 12'((8 * k) % 4096);
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    tick();
    k++;
  endtask

  task automatic send_until(input int last);
    while (k <= last) apply_stimulus();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic read_check(input string tag, input int addr, input int expected);
    rd_addr = 9'(addr);
    tick();
    check_output(tag, int'(rd_data), expected);
  endtask

  initial begin
    reset      = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    trig_level = '0;
    arm        = 1'b0;
    force_trig = 1'b0;
`ifdef SCOPE_TRIG_SLOPE_EN
    trig_slope = 1'b0;
`endif
    rd_addr    = '0;
    tick();
    tick();
    check_output("reset_rd_data", int'(rd_data), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_triggered", int'(triggered), 0);
    reset = 1'b0;

    // Idle stream plus a stray force_trig must not start anything
    k = 0;
    send_until(9);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    check_output("idle_busy", int'(busy), 0);
    check_output("idle_done", int'(done), 0);
    check_output("idle_triggered", int'(triggered), 0);

    // Rising crossing at k=256
    trig_level = 12'd2048;
    k = 0;
    pulse_arm();
    check_output("s2_busy_after_arm", int'(busy), 1);
    send_until(255);
    check_output("s2_not_yet_triggered", int'(triggered), 0);
    apply_stimulus();
    check_output("s2_triggered", int'(triggered), 1);
    send_until(638);
    check_output("s2_done_early", int'(done), 0);
    apply_stimulus();
    check_output("s2_done", int'(done), 1);
    check_output("s2_busy_done", int'(busy), 0);
    read_check("s2_rd0", 0, 1024);
    rd_addr = 9'd128;
    #2;
    check_output("s2_rd_latency", int'(rd_data), 1024);
    tick();
    check_output("s2_rd128", int'(rd_data), 2048);
    read_check("s2_rd511", 511, 1016);

    // Forced trigger with no sample pending, before k=300
    trig_level = 12'd4095;
    k = 0;
    pulse_arm();
    check_output("s3_done_drops", int'(done), 0);
    send_until(299);
    check_output("s3_no_crossing", int'(triggered), 0);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    check_output("s3_triggered", int'(triggered), 1);
    send_until(682);
    check_output("s3_done_early", int'(done), 0);
    apply_stimulus();
    check_output("s3_done", int'(done), 1);
    read_check("s3_rd0", 0, 1376);
    read_check("s3_rd128", 128, 2400);
    read_check("s3_rd511", 511, 1368);

    // Arm pulses mid-capture and a later crossing are ignored
    trig_level = 12'd2048;
    k = 0;
    pulse_arm();
    send_until(50);
    pulse_arm();
    send_until(400);
    pulse_arm();
    check_output("s4_busy_post", int'(busy), 1);
    send_until(768);
    check_output("s4_done", int'(done), 1);
    check_output("s4_triggered", int'(triggered), 1);
    read_check("s4_rd0", 0, 1024);
    read_check("s4_rd128", 128, 2048);
    read_check("s4_rd511", 511, 1016);

    // Reset during POST, then re-arm
    k = 0;
    pulse_arm();
    send_until(400);
    check_output("s5_busy_pre_reset", int'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("s5_busy", int'(busy), 0);
    check_output("s5_done", int'(done), 0);
    check_output("s5_triggered", int'(triggered), 0);
    pulse_arm();
    send_until(767);
    check_output("s5_no_trig_at_wrap", int'(triggered), 0);
    apply_stimulus();
    check_output("s5_triggered_768", int'(triggered), 1);
    send_until(1150);
    check_output("s5_done_early", int'(done), 0);
    apply_stimulus();
    check_output("s5_done_final", int'(done), 1);
    read_check("s5_rd128", 128, 2048);
    read_check("s5_rd0", 0, 1024);
    read_check("s5_rd511", 511, 1016);

`ifdef SCOPE_TRIG_SLOPE_EN
    // Falling crossing at the wrap k=512; slope changes mid-capture are ignored
    trig_level = 12'd8;
    trig_slope = 1'b1;
    k = 0;
    pulse_arm();
    trig_slope = 1'b0;
    send_until(511);
    check_output("s6_not_yet_triggered", int'(triggered), 0);
    apply_stimulus();
    check_output("s6_triggered", int'(triggered), 1);
    send_until(895);
    check_output("s6_done", int'(done), 1);
    read_check("s6_rd128", 128, 0);
    read_check("s6_rd127", 127, 4088);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
